core_bus_target: RTL and testbench

//   Target (responder) side of the core bus: serves bus_start/bus_ready transactions issued by the arm810 core.

---
 rtl/core_bus_target.sv | 150 +++++++++++++++
 tb/tb_core_bus_target.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_target.sv
// Responder for the core bus: a word-addressed RAM window with fixed response latency,
// plus sticky flags for out-of-window accesses and starts issued while a response is pending.
module core_bus_target #(
    parameter logic [29:0] ADDR_BASE   = 30'h0,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] bus_addr,
    input  logic        bus_start,
    input  logic        bus_write,
    input  logic [31:0] bus_data_wr,
    output logic        bus_ready,
    output logic [31:0] bus_data_rd,
    output logic        busy,
    output logic        range_err,
    output logic        proto_err,
    output logic [29:0] err_addr,
    input  logic        err_clr
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [29:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        r_hit;
    logic        r_ready;
    logic [31:0] r_ram [DEPTH];

    // Offset compare wraps modulo 2**30, so addresses below the base miss too.
    function automatic logic in_window(input logic [29:0] a);
        logic [29:0] off;
        off = a - ADDR_BASE;
        return (off >> DEPTH_LOG2) == 30'd0;
    endfunction

    logic                  w_accept;
    logic                  w_enter_resp;
    logic [29:0]           w_txn_addr;
    logic                  w_txn_write;
    logic                  w_txn_hit;
    logic [DEPTH_LOG2-1:0] w_txn_idx;
    logic                  w_commit;
    logic                  w_bypass;
    logic                  w_range_evt;
    logic                  w_proto_evt;
    logic                  w_armed;
    logic [29:0]           w_err_addr_evt;

    // The RAM read is issued in the cycle before RESP: with no wait states that is
    // the accepting cycle itself, so the live bus inputs are used instead of the latches.
    assign w_accept     = bus_start && (r_state == S_IDLE || r_state == S_RESP);
    assign w_enter_resp = (WAIT_STATES == 0) ? w_accept
                                             : (r_state == S_WAIT && r_cnt == 4'd1);
    assign w_txn_addr   = (WAIT_STATES == 0) ? bus_addr  : r_addr;
    assign w_txn_write  = (WAIT_STATES == 0) ? bus_write : r_write;
    assign w_txn_hit    = in_window(w_txn_addr);
    assign w_txn_idx    = w_txn_addr[DEPTH_LOG2-1:0];

    // A back-to-back read of the word being written this edge must see the new value.
    assign w_commit     = (r_state == S_RESP) && r_write && r_hit;
    assign w_bypass     = w_commit && (r_addr[DEPTH_LOG2-1:0] == w_txn_idx);

    assign w_range_evt    = (r_state == S_RESP) && !r_hit;
    assign w_proto_evt    = (r_state == S_WAIT) && bus_start;
    assign w_armed        = (!range_err && !proto_err) || err_clr;
    assign w_err_addr_evt = w_proto_evt ? bus_addr : r_addr;

    assign bus_ready = r_ready;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            r_ram[r_addr[DEPTH_LOG2-1:0]] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 30'd0;
            r_write     <= 1'b0;
            r_wdata     <= 32'd0;
            r_hit       <= 1'b0;
            r_ready     <= 1'b0;
            bus_data_rd <= 32'd0;
            range_err   <= 1'b0;
            proto_err   <= 1'b0;
            err_addr    <= 30'd0;
        end else begin
            r_ready <= w_enter_resp;

            if (w_enter_resp && !w_txn_write) begin
                if (!w_txn_hit)
                    bus_data_rd <= 32'd0;
                else if (w_bypass)
                    bus_data_rd <= r_wdata;
                else
                    bus_data_rd <= r_ram[w_txn_idx];
            end

            if (w_accept) begin
                r_addr  <= bus_addr;
                r_write <= bus_write;
                r_wdata <= bus_data_wr;
                r_hit   <= in_window(bus_addr);
            end

            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                        r_cnt   <= WS;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1)
                        r_state <= S_RESP;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase

            // A fresh error in the same cycle as err_clr takes precedence.
            if (err_clr) begin
                range_err <= 1'b0;
                proto_err <= 1'b0;
                err_addr  <= 30'd0;
            end
            if (w_range_evt)
                range_err <= 1'b1;
            if (w_proto_evt)
                proto_err <= 1'b1;
            if ((w_range_evt || w_proto_evt) && w_armed)
                err_addr <= w_err_addr_evt;
        end
    end

endmodule

// File: tb/tb_core_bus_target.sv
// Bench for core_bus_target: three instances with 0, 1 and 2 wait states, driven by directed
// and random transactions and checked against a word-array memory model and latency arithmetic.
module tb_core_bus_target;

    localparam logic [29:0] BASE = 30'h100;
    localparam int          DL   = 6;
    localparam int          NW   = 64;

    logic        clk = 1'b0;
    logic        rst      [3];
    logic [29:0] addr     [3];
    logic        start    [3];
    logic        wr       [3];
    logic [31:0] wdata    [3];
    logic        ready    [3];
    logic [31:0] rdata    [3];
    logic        busy     [3];
    logic        rerr     [3];
    logic        perr     [3];
    logic [29:0] eaddr    [3];
    logic        eclr     [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        core_bus_target #(
            .ADDR_BASE  (BASE),
            .DEPTH_LOG2 (DL),
            .WAIT_STATES(gi)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[gi]),
            .bus_addr   (addr[gi]),
            .bus_start  (start[gi]),
            .bus_write  (wr[gi]),
            .bus_data_wr(wdata[gi]),
            .bus_ready  (ready[gi]),
            .bus_data_rd(rdata[gi]),
            .busy       (busy[gi]),
            .range_err  (rerr[gi]),
            .proto_err  (perr[gi]),
            .err_addr   (eaddr[gi]),
            .err_clr    (eclr[gi])
        );
    end

    // Reference model: memory contents, which words are known, last read data, first-error tracking.
    logic [31:0] m_mem  [3][NW];
    bit          m_val  [3][NW];
    logic [31:0] m_rd   [3];
    bit          m_err  [3];
    logic [29:0] m_eaddr[3];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [29:0] a);
        logic [29:0] off;
        off = a - BASE;
        return off < 30'(NW);
    endfunction

    task automatic do_txn(input int k, input logic [29:0] a, input logic w, input logic [31:0] d);
        int n;
        bit hit;
        int idx;
        hit = model_hit(a);
        idx = int'((a - BASE) % NW);
        @(negedge clk);
        addr[k] = a; wr[k] = w; wdata[k] = d; start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        addr[k]  = 30'($urandom);
        wdata[k] = $urandom;
        wr[k]    = ~w;
        n = 0;
        while (!ready[k] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("latency k%0d a%h", k, a), 32'(n), 32'(k));
        if (w) begin
            chk($sformatf("wr_keeps_rd k%0d", k), rdata[k], m_rd[k]);
            if (hit) begin
                m_mem[k][idx] = d;
                m_val[k][idx] = 1'b1;
            end
        end else if (!hit) begin
            m_rd[k] = 32'd0;
            chk($sformatf("miss_rd k%0d a%h", k, a), rdata[k], 32'd0);
        end else if (m_val[k][idx]) begin
            m_rd[k] = m_mem[k][idx];
            chk($sformatf("rd k%0d a%h", k, a), rdata[k], m_mem[k][idx]);
        end else begin
            m_rd[k] = rdata[k];
        end
        if (!hit && !m_err[k]) begin
            m_err[k]   = 1'b1;
            m_eaddr[k] = a;
        end
        @(posedge clk); #1;
        chk($sformatf("ready_1cyc k%0d", k), 32'(ready[k]), 32'd0);
    endtask

    task automatic clear_err(input int k);
        @(negedge clk); eclr[k] = 1'b1;
        @(negedge clk); eclr[k] = 1'b0;
        m_err[k] = 1'b0;
        chk($sformatf("clr_range k%0d", k), 32'(rerr[k]), 32'd0);
        chk($sformatf("clr_proto k%0d", k), 32'(perr[k]), 32'd0);
        chk($sformatf("clr_eaddr k%0d", k), 32'(eaddr[k]), 32'd0);
    endtask

    initial begin
        int cnt;
        logic [29:0] a;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; addr[k] = '0; start[k] = 1'b0; wr[k] = 1'b0;
            wdata[k] = '0; eclr[k] = 1'b0; m_rd[k] = 32'd0; m_err[k] = 1'b0; m_eaddr[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready k%0d", k), 32'(ready[k]), 32'd0);
            chk($sformatf("rst_rd k%0d", k), rdata[k], 32'd0);
            chk($sformatf("rst_busy k%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_range k%0d", k), 32'(rerr[k]), 32'd0);
            chk($sformatf("rst_proto k%0d", k), 32'(perr[k]), 32'd0);
        end

        // One wait state: write then read back the same word.
        do_txn(1, BASE + 30'd5, 1'b1, 32'hCAFEF00D);
        do_txn(1, BASE + 30'd5, 1'b0, 32'h0);
        chk("cafe_rd", rdata[1], 32'hCAFEF00D);

        // Random traffic on every instance, with occasional out-of-window addresses.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 9))
                    0:       a = BASE + 30'(NW) + 30'($urandom_range(0, 500));
                    1:       a = BASE - 30'd1 - 30'($urandom_range(0, 50));
                    default: a = BASE + 30'($urandom_range(0, NW - 1));
                endcase
                do_txn(k, a, 1'($urandom), $urandom);
            end
            chk($sformatf("rand_range k%0d", k), 32'(rerr[k]), 32'(m_err[k]));
            chk($sformatf("rand_eaddr k%0d", k), 32'(eaddr[k]), m_err[k] ? 32'(m_eaddr[k]) : 32'd0);
            chk($sformatf("rand_proto k%0d", k), 32'(perr[k]), 32'd0);
        end

        // Zero wait states: start held for four cycles reading words 0..3.
        for (int i = 0; i < 4; i++) do_txn(0, BASE + 30'(i), 1'b1, 32'hA5A50000 + 32'(i));
        @(negedge clk);
        start[0] = 1'b1; wr[0] = 1'b0; addr[0] = BASE;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) start[0] = 1'b0;
            else addr[0] = BASE + 30'(i + 1);
            chk($sformatf("burst_ready %0d", i), 32'(ready[0]), 32'd1);
            chk($sformatf("burst_rd %0d", i), rdata[0], 32'hA5A50000 + 32'(i));
        end
        @(posedge clk); #1;
        chk("burst_end", 32'(ready[0]), 32'd0);

        // Zero wait states: write immediately followed by a read of the same word.
        @(negedge clk);
        start[0] = 1'b1; wr[0] = 1'b1; addr[0] = BASE + 30'd7; wdata[0] = 32'h1234ABCD;
        @(posedge clk); #1;
        wr[0] = 1'b0; wdata[0] = 32'h0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        chk("b2b_ready", 32'(ready[0]), 32'd1);
        chk("b2b_rd", rdata[0], 32'h1234ABCD);
        m_mem[0][7] = 32'h1234ABCD; m_val[0][7] = 1'b1; m_rd[0] = 32'h1234ABCD;
        @(posedge clk); #1;

        // Out-of-window read just past the end of the window.
        clear_err(1);
        do_txn(1, BASE + 30'(NW), 1'b0, 32'h0);
        chk("oow_range", 32'(rerr[1]), 32'd1);
        chk("oow_eaddr", 32'(eaddr[1]), 32'(BASE + 30'(NW)));
        do_txn(1, BASE + 30'(NW) + 30'd3, 1'b0, 32'h0);
        chk("oow_first_wins", 32'(eaddr[1]), 32'(BASE + 30'(NW)));
        clear_err(1);

        // Two wait states: a second start while waiting is ignored and flagged.
        do_txn(2, BASE + 30'd3, 1'b1, 32'h0BADBEEF);
        clear_err(2);
        @(negedge clk);
        start[2] = 1'b1; wr[2] = 1'b0; addr[2] = BASE + 30'd3;
        @(posedge clk); #1;
        addr[2] = BASE + 30'd9;
        @(posedge clk); #1;
        start[2] = 1'b0;
        chk("proto_early", 32'(ready[2]), 32'd0);
        @(posedge clk); #1;
        chk("proto_ready", 32'(ready[2]), 32'd1);
        chk("proto_rd", rdata[2], 32'h0BADBEEF);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready[2]) cnt++;
        end
        chk("proto_single", 32'(cnt), 32'd0);
        chk("proto_err", 32'(perr[2]), 32'd1);
        chk("proto_eaddr", 32'(eaddr[2]), 32'(BASE + 30'd9));
        chk("proto_range", 32'(rerr[2]), 32'd0);

        // Reset lands mid-transaction: no response and the RAM word keeps its old value.
        do_txn(1, BASE + 30'd12, 1'b1, 32'h11112222);
        @(negedge clk);
        start[1] = 1'b1; wr[1] = 1'b1; addr[1] = BASE + 30'd12; wdata[1] = 32'h99998888;
        @(posedge clk); #1;
        start[1] = 1'b0;
        @(negedge clk); rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (ready[1]) cnt++;
            @(posedge clk); #1;
        end
        chk("rst_abort_ready", 32'(cnt), 32'd0);
        chk("rst_abort_busy", 32'(busy[1]), 32'd0);
        m_rd[1] = 32'd0; m_err[1] = 1'b0;
        do_txn(1, BASE + 30'd12, 1'b0, 32'h0);
        chk("rst_abort_old", rdata[1], 32'h11112222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
